aes_sbox_checker: RTL and testbench
===================================

AES_SBOX_CHECKER -- requirements
Module: aes_sbox_checker

Interface
REQ-001 Parameter SHARES, default 2: number of Boolean shares per byte on both the X and Q buses.
REQ-002 Parameter LATENCY, default 5: clock edges from a byte applied on _XxDI to its shares appearing on _QxDI (masked S-box latency, PIPELINED=1).
REQ-003 Parameter NUM_CHECKS, default 65536: number of valid checks that completes a run.
REQ-004 ClkxCI  in  1: the single clock; all state updates on the rising edge.
REQ-005 RstxBI  in  1: reset, synchronous, active-low.
REQ-006 StartxSI  in  1: single-cycle pulse that clears all results and starts a run.
REQ-007 ValidxSI  in  1: _XxDI carries a sample to be checked this cycle.
REQ-008 _XxDI  in  8*SHARES: input shares driven to the masked S-box; share i occupies bits [8i+7:8i].
REQ-009 _QxDI  in  8*SHARES: output shares returned by the masked S-box; same packing as _XxDI.
REQ-010 BusyxSO  out  1: high in state RUN.
REQ-011 DonexSO  out  1: high in state DONE.
REQ-012 ErrFlagxSO  out  1: sticky flag, set by any mismatch in the current run.
REQ-013 CheckCntxDO  out  32: number of comparisons performed in the current run.
REQ-014 ErrCntxDO  out  16: number of mismatches, saturating.
REQ-015 FirstErrXxDO  out  8: unmasked input byte of the first mismatch.
REQ-016 FirstErrQxDO  out  8: unmasked output byte of the first mismatch.

Function
REQ-017 Unmasked input X = XOR of all SHARES bytes of _XxDI; unmasked output Q = XOR of all SHARES bytes of _QxDI.
REQ-018 Delay line: LATENCY stages of {valid, X}, shifting every cycle; stage 0 loads {ValidxSI, X}.
REQ-019 The tail stage is aligned with the current _QxDI; the block compares Q with SBOX(X_tail), where SBOX is the unmasked AES forward S-box.
REQ-020 A comparison counts only when the tail valid bit = 1 and the state is RUN.
REQ-021 Counters and flags are registered; a sample valid at edge k is reflected in the outputs after edge k+LATENCY.
REQ-022 FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on StartxSI.
  - RUN -> DONE on the edge at which CheckCnt reaches NUM_CHECKS.
  - DONE -> RUN on StartxSI.
REQ-023 StartxSI in any state, including mid-RUN, performs all of the following in the same edge:
  - clears CheckCnt, ErrCnt, ErrFlag, FirstErrX and FirstErrQ;
  - clears every delay-line valid bit;
  - enters RUN.
REQ-024 StartxSI coinciding with a counted comparison: the clear wins and the comparison is discarded.
REQ-025 Each counted comparison increments CheckCnt by 1; no further checks are counted once the count equals NUM_CHECKS.
REQ-026 A mismatch increments ErrCnt, saturating at 16'hFFFF, and sets ErrFlag.
REQ-027 FirstErrX/FirstErrQ load only on the mismatch that occurs while ErrFlag = 0.
REQ-028 In IDLE and DONE:
  - the delay line keeps shifting;
  - all counters, flags and capture registers hold their values.
REQ-029 ValidxSI is sampled in every state, and is accepted in the same cycle as StartxSI (the flush precedes the load into stage 0).

Reset
REQ-030 RstxBI = 0 at a rising edge forces:
  - FSM to IDLE;
  - all delay-line valid bits to 0;
  - CheckCnt, ErrCnt, ErrFlag, FirstErrX and FirstErrQ to 0.
REQ-031 Reset values of outputs: BusyxSO = 0, DonexSO = 0, all others 0.
REQ-032 Reset dominates StartxSI; reset mid-RUN abandons the run with no partial results retained.
REQ-033 Delay-line data bits need no reset.

Structure
REQ-034 Package aes_sbox_pkg holds:
  - the FSM state typedef;
  - the default SHARES and LATENCY constants;
  - a function returning the masked S-box latency for PIPELINED = 0/1.
REQ-035 One sub-module, aes_sbox_ref: an unmasked combinational 256x8 forward S-box lookup, instantiated once on X_tail.
REQ-036 Expected size: 150-300 lines of RTL.

Verification
REQ-037 Clean sweep: reset, Start, then 65536 valid samples pairing masked aes_sbox (PIPELINED=1, SHARES=2) with random Z/B inputs -> DonexSO = 1, CheckCnt = 65536, ErrCnt = 0, ErrFlag = 0.
REQ-038 Fault injection: invert bit 0 of share 1 of _QxDI for X = 8'h53 only -> ErrCnt = 1, FirstErrX = 8'h53, FirstErrQ = 8'hEC (expected 8'hED).
REQ-039 Latency alignment: single valid sample X = 8'h00 -> CheckCnt becomes 1 exactly after edge k+LATENCY, compared Q = 8'h63; unchanged before that edge.
REQ-040 Restart mid-run: Start after 100 checks with 3 samples in flight -> counters = 0 and the 3 flushed samples are never counted.
REQ-041 Saturation: NUM_CHECKS = 70000 with a constant-corrupted Q -> ErrCnt holds 16'hFFFF, ErrFlag = 1, FirstErrX equals the first sample's X.
REQ-042 Reset mid-RUN, asserted together with StartxSI -> IDLE, all outputs 0, and subsequent valid samples are not counted until the next Start.

Source files
------------

// File: rtl/aes_sbox_pkg.sv
// Shared types and constants for the AES S-box checker.
package aes_sbox_pkg;

  // FSM encoding kept as plain constants so older tools see fixed values
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam int SHARES_DEF  = 2;
  localparam int LATENCY_DEF = 5;

  // Edges from masked S-box input to output shares, by pipelining option
  function automatic int sbox_latency(input bit pipelined);
    return pipelined ? LATENCY_DEF : 1;
  endfunction

endpackage

// File: rtl/aes_sbox_checker_if.sv
// Stimulus/result bus between the masked S-box harness and the checker.
interface aes_sbox_checker_if #(
  parameter int SHARES = 2
);
  logic                  i_StartxSI;
  logic                  i_ValidxSI;
  logic [8*SHARES-1:0]   i_XxDI;
  logic [8*SHARES-1:0]   i_QxDI;
  logic                  o_BusyxSO;
  logic                  o_DonexSO;
  logic                  o_ErrFlagxSO;
  logic [31:0]           o_CheckCntxDO;
  logic [15:0]           o_ErrCntxDO;
  logic [7:0]            o_FirstErrXxDO;
  logic [7:0]            o_FirstErrQxDO;

  modport master (
    output i_StartxSI, i_ValidxSI, i_XxDI, i_QxDI,
    input  o_BusyxSO, o_DonexSO, o_ErrFlagxSO, o_CheckCntxDO,
           o_ErrCntxDO, o_FirstErrXxDO, o_FirstErrQxDO
  );

  modport slave (
    input  i_StartxSI, i_ValidxSI, i_XxDI, i_QxDI,
    output o_BusyxSO, o_DonexSO, o_ErrFlagxSO, o_CheckCntxDO,
           o_ErrCntxDO, o_FirstErrXxDO, o_FirstErrQxDO
  );
endinterface

// File: rtl/aes_sbox_ref.sv
// Unmasked AES forward S-box, pure combinational table lookup.
module aes_sbox_ref (
  input  logic [7:0] i_XxD,
  output logic [7:0] o_QxD
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign o_QxD = SBOX[i_XxD];
endmodule

// File: rtl/aes_sbox_checker.sv
// Checks a masked S-box against the unmasked reference: unmasks X and Q,
// delays X by the S-box latency and counts matches/mismatches per run.
module aes_sbox_checker
  import aes_sbox_pkg::*;
#(
  parameter int SHARES     = SHARES_DEF,
  parameter int LATENCY    = sbox_latency(1'b1),
  parameter int NUM_CHECKS = 65536
)(
  input logic              i_ClkxCI,
  input logic              i_RstxBI,
  aes_sbox_checker_if.slave bus
);
  localparam logic [31:0] NUM_C = 32'(NUM_CHECKS);

  state_t             r_State;
  logic [LATENCY-1:0] r_VldPipe;
  logic [7:0]         r_XPipe [LATENCY];
  logic [31:0]        r_CheckCnt;
  logic [15:0]        r_ErrCnt;
  logic               r_ErrFlag;
  logic [7:0]         r_FirstErrX, r_FirstErrQ;

  logic [7:0] w_X, w_Q, w_QExp;
  logic       w_Count, w_Mis;

  // Recombine shares into the unmasked input and output bytes
  always_comb begin
    w_X = '0;
    w_Q = '0;
    for (int i = 0; i < SHARES; i++) begin
      w_X = w_X ^ bus.i_XxDI[8*i +: 8];
      w_Q = w_Q ^ bus.i_QxDI[8*i +: 8];
    end
  end

  // Valid shift register: Start flushes in-flight samples but keeps the new one
  always_ff @(posedge i_ClkxCI) begin
    if (!i_RstxBI) begin
      r_VldPipe <= '0;
    end else begin
      for (int i = LATENCY-1; i > 0; i--)
        r_VldPipe[i] <= bus.i_StartxSI ? 1'b0 : r_VldPipe[i-1];
      r_VldPipe[0] <= bus.i_ValidxSI;
    end
  end

  // X data pipe, no reset needed since valid bits qualify it
  always_ff @(posedge i_ClkxCI) begin
    r_XPipe[0] <= w_X;
    for (int i = 1; i < LATENCY; i++) r_XPipe[i] <= r_XPipe[i-1];
  end

  aes_sbox_ref u_ref (
    .i_XxD (r_XPipe[LATENCY-1]),
    .o_QxD (w_QExp)
  );

  // A Start on the same edge discards the comparison at the tail
  assign w_Count = (r_State == S_RUN) && r_VldPipe[LATENCY-1] &&
                   !bus.i_StartxSI && (r_CheckCnt < NUM_C);
  assign w_Mis   = w_Count && (w_Q != w_QExp);

  // Run control and result registers
  always_ff @(posedge i_ClkxCI) begin
    if (!i_RstxBI) begin
      r_State     <= S_IDLE;
      r_CheckCnt  <= '0;
      r_ErrCnt    <= '0;
      r_ErrFlag   <= 1'b0;
      r_FirstErrX <= '0;
      r_FirstErrQ <= '0;
    end else if (bus.i_StartxSI) begin
      r_State     <= S_RUN;
      r_CheckCnt  <= '0;
      r_ErrCnt    <= '0;
      r_ErrFlag   <= 1'b0;
      r_FirstErrX <= '0;
      r_FirstErrQ <= '0;
    end else if (w_Count) begin
      r_CheckCnt <= r_CheckCnt + 32'd1;
      if (r_CheckCnt + 32'd1 == NUM_C) r_State <= S_DONE;
      if (w_Mis) begin
        if (r_ErrCnt != 16'hFFFF) r_ErrCnt <= r_ErrCnt + 16'd1;
        r_ErrFlag <= 1'b1;
        if (!r_ErrFlag) begin
          r_FirstErrX <= r_XPipe[LATENCY-1];
          r_FirstErrQ <= w_Q;
        end
      end
    end
  end

  assign bus.o_BusyxSO      = (r_State == S_RUN);
  assign bus.o_DonexSO      = (r_State == S_DONE);
  assign bus.o_ErrFlagxSO   = r_ErrFlag;
  assign bus.o_CheckCntxDO  = r_CheckCnt;
  assign bus.o_ErrCntxDO    = r_ErrCnt;
  assign bus.o_FirstErrXxDO = r_FirstErrX;
  assign bus.o_FirstErrQxDO = r_FirstErrQ;
endmodule

// File: tb/tb_aes_sbox_checker.sv
// Bench for aes_sbox_checker: behavioural masked S-box source (GF(2^8) math)
// plus a run-level model of the expected counters, compared every cycle.
module tb_aes_sbox_checker;
  localparam int SH    = 2;
  localparam int LAT   = 5;
  localparam int NUM_M = 65536;
  localparam int NUM_S = 70000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_sbox_checker_if #(.SHARES(SH)) bus_m ();
  aes_sbox_checker_if #(.SHARES(SH)) bus_s ();

  aes_sbox_checker #(.SHARES(SH), .LATENCY(LAT), .NUM_CHECKS(NUM_M)) u_dut (
    .i_ClkxCI(clk), .i_RstxBI(rst_n), .bus(bus_m));
  aes_sbox_checker #(.SHARES(SH), .LATENCY(LAT), .NUM_CHECKS(NUM_S)) u_sat (
    .i_ClkxCI(clk), .i_RstxBI(rst_n), .bus(bus_s));

  int n_vec = 0, n_err = 0;

  // sample history: index 0 = byte applied this cycle, LAT = byte due now on Q
  bit [7:0] sx [LAT+1];
  bit       sv [LAT+1];
  bit [7:0] sf [LAT+1];

  bit          mrun, mdone, mflag;
  int unsigned mcnt, merr;
  bit [7:0]    mfx, mfq;

  function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
    bit [7:0] r = 0, aa = a, bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) r ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return r;
  endfunction

  // S-box from its definition: GF(2^8) inverse (a^254) then affine map
  function automatic bit [7:0] sbox_f(input bit [7:0] a);
    bit [7:0] r = 8'h01, p = a, s;
    int e = 254;
    while (e != 0) begin
      if (e[0]) r = gmul(r, p);
      p = gmul(p, p);
      e = e >> 1;
    end
    s = 8'h63;
    for (int k = 0; k < 5; k++) s ^= (r << k) | (r >> (8 - k));
    return s;
  endfunction

  function automatic bit [8*SH-1:0] split(input bit [7:0] v);
    bit [8*SH-1:0] sh;
    bit [7:0] acc = v, m;
    for (int i = 1; i < SH; i++) begin
      m = 8'($urandom);
      sh[8*i +: 8] = m;
      acc ^= m;
    end
    sh[7:0] = acc;
    return sh;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  // flip is XORed into share 1 of Q when this byte reaches the output.
  task automatic cyc(input bit rst, input bit st, input bit v, input bit [7:0] x,
                     input bit [7:0] flip);
    bit [8*SH-1:0] q;
    for (int i = LAT; i > 0; i--) begin
      sx[i] = sx[i-1]; sv[i] = sv[i-1]; sf[i] = sf[i-1];
    end
    sx[0] = x; sv[0] = v; sf[0] = flip;

    rst_n = ~rst;
    bus_m.i_StartxSI = st; bus_m.i_ValidxSI = v; bus_m.i_XxDI = split(x);
    bus_s.i_StartxSI = st; bus_s.i_ValidxSI = v; bus_s.i_XxDI = split(x);
    q = split(sbox_f(sx[LAT]));
    q[15:8] ^= sf[LAT];
    bus_m.i_QxDI = q;
    bus_s.i_QxDI = split(sbox_f(sx[LAT]) ^ 8'hFF);

    if (rst) begin
      mrun = 0; mdone = 0; mcnt = 0; merr = 0; mflag = 0; mfx = 0; mfq = 0;
      for (int i = 0; i <= LAT; i++) sv[i] = 0;
    end else if (st) begin
      mrun = 1; mdone = 0; mcnt = 0; merr = 0; mflag = 0; mfx = 0; mfq = 0;
      for (int i = 1; i <= LAT; i++) sv[i] = 0;
    end else if (mrun && sv[LAT]) begin
      mcnt++;
      if (sf[LAT] != 0) begin
        if (merr < 65535) merr++;
        if (!mflag) begin mfx = sx[LAT]; mfq = sbox_f(sx[LAT]) ^ sf[LAT]; end
        mflag = 1;
      end
      if (mcnt == NUM_M) begin mrun = 0; mdone = 1; end
    end

    @(posedge clk); #1;
    chk("busy",   bus_m.o_BusyxSO,      mrun);
    chk("done",   bus_m.o_DonexSO,      mdone);
    chk("cnt",    bus_m.o_CheckCntxDO,  mcnt);
    chk("errcnt", bus_m.o_ErrCntxDO,    merr);
    chk("flag",   bus_m.o_ErrFlagxSO,   mflag);
    chk("fx",     bus_m.o_FirstErrXxDO, mfx);
    chk("fq",     bus_m.o_FirstErrQxDO, mfq);
  endtask

  function automatic bit [7:0] rnd_no53();
    bit [7:0] r = 8'($urandom);
    return (r == 8'h53) ? 8'h54 : r;
  endfunction

  initial begin
    bit [7:0] first_x, x;

    // reset
    repeat (3) cyc(1, 0, 0, 8'h00, 0);
    chk("sat_rst_cnt",  bus_s.o_CheckCntxDO, 0);
    chk("sat_rst_busy", bus_s.o_BusyxSO, 0);

    // clean sweep on main, constant-corrupted Q on the saturation instance
    cyc(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < NUM_M; i++) begin
      x = 8'($urandom);
      if (i == 0) first_x = x;
      cyc(0, 0, 1, x, 0);
    end
    repeat (LAT) cyc(0, 0, 0, 8'h00, 0);
    chk("sweep_done",  bus_m.o_DonexSO, 1);
    chk("sweep_cnt",   bus_m.o_CheckCntxDO, 65536);
    chk("sweep_err",   bus_m.o_ErrCntxDO, 0);
    chk("sweep_flag",  bus_m.o_ErrFlagxSO, 0);
    chk("sat_err",     bus_s.o_ErrCntxDO, 16'hFFFF);
    chk("sat_flag",    bus_s.o_ErrFlagxSO, 1);
    chk("sat_cnt",     bus_s.o_CheckCntxDO, 65536);
    chk("sat_fx",      bus_s.o_FirstErrXxDO, first_x);
    chk("sat_fq",      bus_s.o_FirstErrQxDO, sbox_f(first_x) ^ 8'hFF);
    chk("sat_busy",    bus_s.o_BusyxSO, 1);

    // DONE holds while samples keep arriving
    repeat (LAT + 3) cyc(0, 0, 1, 8'($urandom), 8'h01);
    chk("done_hold", bus_m.o_CheckCntxDO, 65536);

    // latency alignment with a single X = 00
    cyc(0, 1, 0, 8'h00, 0);
    cyc(0, 0, 1, 8'h00, 0);
    chk("lat_k", bus_m.o_CheckCntxDO, 0);
    for (int i = 1; i < LAT; i++) begin
      cyc(0, 0, 0, 8'h00, 0);
      chk("lat_early", bus_m.o_CheckCntxDO, 0);
    end
    cyc(0, 0, 0, 8'h00, 0);
    chk("lat_hit", bus_m.o_CheckCntxDO, 1);
    chk("lat_err", bus_m.o_ErrCntxDO, 0);

    // fault injection on X = 53 only
    cyc(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 40; i++) begin
      if (i == 20) cyc(0, 0, 1, 8'h53, 8'h01);
      else         cyc(0, 0, 1, rnd_no53(), 0);
    end
    repeat (LAT) cyc(0, 0, 0, 8'h00, 0);
    chk("flt_err",  bus_m.o_ErrCntxDO, 1);
    chk("flt_fx",   bus_m.o_FirstErrXxDO, 8'h53);
    chk("flt_fq",   bus_m.o_FirstErrQxDO, 8'hEC);
    chk("flt_flag", bus_m.o_ErrFlagxSO, 1);
    chk("flt_cnt",  bus_m.o_CheckCntxDO, 40);

    // restart after 100 checks with 3 in flight (start also collides with a compare)
    cyc(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 103; i++) cyc(0, 0, 1, 8'($urandom), 8'h01);
    repeat (2) cyc(0, 0, 0, 8'h00, 0);
    chk("rs_cnt100", bus_m.o_CheckCntxDO, 100);
    chk("rs_err100", bus_m.o_ErrCntxDO, 100);
    cyc(0, 1, 0, 8'h00, 0);
    chk("rs_clr", bus_m.o_CheckCntxDO, 0);
    repeat (LAT + 2) cyc(0, 0, 0, 8'h00, 0);
    chk("rs_flushed", bus_m.o_CheckCntxDO, 0);
    chk("rs_err",     bus_m.o_ErrCntxDO, 0);

    // reset together with start mid-run
    cyc(0, 1, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'($urandom), 8'h02);
    cyc(1, 1, 1, 8'($urandom), 8'h02);
    chk("rst_busy", bus_m.o_BusyxSO, 0);
    chk("rst_cnt",  bus_m.o_CheckCntxDO, 0);
    chk("rst_fq",   bus_m.o_FirstErrQxDO, 0);
    repeat (LAT + 3) cyc(0, 0, 1, 8'($urandom), 8'h02);
    chk("rst_nocount", bus_m.o_CheckCntxDO, 0);
    chk("rst_idle",    bus_m.o_DonexSO, 0);
    chk("rst_noerr",   bus_m.o_ErrCntxDO, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
